// File: rtl/gray_pkg.sv
// Shared Gray-code helpers used by the decoder pipeline, the encoder and the benches.
package gray_pkg;

  localparam int GRAY_DEFAULT_WIDTH = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Binary bit i is the XOR of every Gray bit at or above i.
  function automatic logic gray_bit(input logic [31:0] g, input int i);
    return ^(g >> i);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 32; i++) begin
      b[i] = gray_bit(g, i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_step_mon.sv
// Flags any transferred word that is not a +1 (mod 2^WIDTH) step from the previous one.
module gray_step_mon
  import gray_pkg::*;
#(
  parameter int WIDTH     = GRAY_DEFAULT_WIDTH,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 xfer,
  input  logic [WIDTH-1:0]     word,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] prev_inc;
  logic             prev_vld;
  logic             bad_step;

  assign prev_inc = prev + WIDTH'(1);
  // The first transfer after reset only seeds prev.
  assign bad_step = xfer & prev_vld & (word != prev_inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev     <= '0;
      prev_vld <= 1'b0;
      step_err <= 1'b0;
      err_cnt  <= '0;
    end else begin
      step_err <= bad_step;
      if (xfer) begin
        prev     <= word;
        prev_vld <= 1'b1;
      end
      if (bad_step && (err_cnt != {ERR_CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/gray_to_binary_pipe.sv
// Two-stage valid/ready Gray-to-binary decoder.
// Define GRAY_STEP_CHECK_EN to build the output step monitor (step_err / err_cnt).
module gray_to_binary_pipe
  import gray_pkg::*;
#(
  parameter int WIDTH     = GRAY_DEFAULT_WIDTH,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_gray,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_bin,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic             v1;
  logic             v2;
  logic             load1;
  logic             load2;
  logic [WIDTH-1:0] g1;
  logic [WIDTH-1:0] dec;

  // No skid buffer: ready ripples combinationally back from out_ready.
  assign load2     = ~v2 | out_ready;
  assign load1     = ~v1 | load2;
  assign in_ready  = load1;
  assign out_valid = v2;

  always_comb begin
    dec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dec[i] = gray_bit(32'(g1), i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      g1 <= '0;
    end else if (load1) begin
      v1 <= in_valid;
      if (in_valid) begin
        g1 <= in_gray;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2      <= 1'b0;
      out_bin <= '0;
    end else if (load2) begin
      v2 <= v1;
      if (v1) begin
        out_bin <= dec;
      end
    end
  end

`ifdef GRAY_STEP_CHECK_EN
  gray_step_mon #(
    .WIDTH     (WIDTH),
    .ERR_CNT_W (ERR_CNT_W)
  ) u_step_mon (
    .clk      (clk),
    .rst_n    (rst_n),
    .xfer     (v2 & out_ready),
    .word     (out_bin),
    .step_err (step_err),
    .err_cnt  (err_cnt)
  );
`else
  assign step_err = 1'b0;
  assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_gray_to_binary_pipe.sv
// Scoreboard bench for gray_to_binary_pipe (WIDTH=4, ERR_CNT_W=2).
module tb_gray_to_binary_pipe;
  import gray_pkg::*;

  localparam int W  = 4;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_gray = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_bin;
  logic          step_err;
  logic [EW-1:0] err_cnt;

  gray_to_binary_pipe #(.WIDTH(W), .ERR_CNT_W(EW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_gray   (in_gray),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .step_err  (step_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit lat_en = 1'b0;
  bit rand_done = 1'b0;
  logic [W-1:0] exp_q[$];
  int lat_q[$];

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference decode: search for the binary value whose Gray code matches.
  function automatic logic [W-1:0] ref_decode(input logic [W-1:0] g);
    for (int b = 0; b < (1 << W); b++) begin
      if (W'(b ^ (b >> 1)) == g) return W'(b);
    end
    return '0;
  endfunction

  function automatic logic [W-1:0] gray_of(input int b);
    return W'(bin2gray(32'(b)));
  endfunction

  task automatic send(input logic [W-1:0] g, input logic [W-1:0] b);
    in_valid = 1'b1;
    in_gray  = g;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(b);
        lat_q.push_back(cyc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL send_timeout actual=no_in_ready required=in_ready");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    lat_q.delete();
    #1;
    chk("rst_async_out_valid", out_valid, 0);
    chk("rst_async_err_cnt", err_cnt, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: pops expected words on every output transfer and tracks the step model.
  initial begin
    logic [W-1:0] e, prv, held;
    bit prv_v, pend, hold_v, exp_s;
    int mcnt, l;
    prv = '0; held = '0; prv_v = 0; pend = 0; hold_v = 0; mcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prv_v = 0; pend = 0; hold_v = 0; mcnt = 0;
      end else begin
`ifdef GRAY_STEP_CHECK_EN
        exp_s = pend;
        if (pend && mcnt != (1 << EW) - 1) mcnt++;
        chk("step_err", step_err, exp_s);
        chk("err_cnt", err_cnt, mcnt);
`else
        chk("step_err_tied", step_err, 0);
        chk("err_cnt_tied", err_cnt, 0);
`endif
        pend = 0;
        if (hold_v) begin
          chk("hold_valid", out_valid, 1);
          if (out_valid) chk("hold_data", out_bin, held);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out actual=%0h required=none", out_bin);
          end else begin
            e = exp_q.pop_front();
            l = lat_q.pop_front();
            chk("out_bin", out_bin, e);
            if (lat_en) chk("latency", cyc - l, 2);
            pend = prv_v && (e != W'(prv + 1));
            prv = e;
            prv_v = 1;
          end
        end
        hold_v = out_valid && !out_ready;
        held = out_bin;
      end
    end
  end

  initial begin
    logic [W-1:0] tbl_g[5];
    logic [W-1:0] tbl_b[5];
    int sat_seq[5];
    tbl_g = '{4'b0000, 4'b0011, 4'b0110, 4'b1100, 4'b1000};
    tbl_b = '{4'b0000, 4'b0010, 4'b0100, 4'b1000, 4'b1111};
    sat_seq = '{5, 9, 2, 7, 12};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bin", out_bin, 0);
    chk("rst_step_err", step_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    lat_en = 1'b1;
    for (int i = 0; i < 5; i++) send(tbl_g[i], tbl_b[i]);
    drain();
    lat_en = 1'b0;

    // Counter walk including wrap, starting from a fresh prev.
    do_reset();
    for (int i = 0; i < 16; i++) send(gray_of(i), W'(i));
    send(gray_of(0), '0);
    drain();
    chk("walk_err_cnt", err_cnt, 0);

    // 0 -> 1 is a legal step, 1 -> 3 is not.
    send(4'b0001, 4'd1);
    send(4'b0010, 4'd3);
    drain();
`ifdef GRAY_STEP_CHECK_EN
    chk("step_err_count", err_cnt, 1);
`else
    chk("step_err_count_tied", err_cnt, 0);
`endif

    for (int i = 0; i < 5; i++) send(gray_of(sat_seq[i]), W'(sat_seq[i]));
    drain();
`ifdef GRAY_STEP_CHECK_EN
    chk("err_cnt_saturated", err_cnt, 3);
`else
    chk("err_cnt_saturated_tied", err_cnt, 0);
`endif

    // Backpressure: two words fill the pipe, the third waits for release.
    out_ready = 1'b0;
    send(gray_of(6), 4'd6);
    send(gray_of(7), 4'd7);
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    chk("full_out_bin", out_bin, 6);
    fork
      send(gray_of(8), 4'd8);
    join_none
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("bp_no_gaps", exp_q.size(), 0);
    drain();

    // Reset with two words in flight.
    out_ready = 1'b0;
    send(gray_of(3), 4'd3);
    send(gray_of(11), 4'd11);
    @(negedge clk);
    chk("pre_rst_out_valid", out_valid, 1);
    do_reset();
    chk("post_rst_out_valid", out_valid, 0);
    out_ready = 1'b1;
    send(gray_of(9), 4'd9);
    send(gray_of(10), 4'd10);
    drain();
    chk("post_rst_err_cnt", err_cnt, 0);

    // Randomised stream with random backpressure and idle gaps.
    fork
      begin
        for (int n = 0; n < 150; n++) begin
          logic [W-1:0] g;
          g = W'($urandom);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(g, ref_decode(g));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
